// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: VGA scan engine (640x480@60 by default) for the maze display.
//   Generates H/V timing and frame-buffer read addresses for a 2x-replicated
//   window. It then returns a 4-bit colour index per pixel, kept aligned with
//   HS/VS/BLANK_N.
//   Everything advances on the pixel tick (one clock in CLK_DIV). Outputs lag
//   the scan counters by RD_LAT+2 ticks.
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   o_fb_addr         frame-buffer read address (holds outside the window)
//   i_fb_data         colour index returned RD_LAT ticks after o_fb_addr
//   o_color_idx       colour index to the RGB decoder (0 when blank/out of window)
//   o_VGA_HS/VS       active-low syncs
//   o_VGA_BLANK_N     high in the visible area
//   o_pix_en          one-clock pixel strobe
//   o_vblank_start    one-clock pulse when the output reaches line V_ACT, column 0
// The H_*/V_* timing parameters default to standard 640x480 timing.
module vga_pixel_fetch #(
  parameter int CLK_DIV = 2,
  parameter int RD_LAT  = 2,
  parameter int WIN_X0  = 96,
  parameter int WIN_Y0  = 0,
  parameter int FB_W    = 224,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 16,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_fb_addr,
  input  logic [3:0]        i_fb_data,
  output logic [3:0]        o_color_idx,
  output logic              o_VGA_HS,
  output logic              o_VGA_VS,
  output logic              o_VGA_BLANK_N,
  output logic              o_pix_en,
  output logic              o_vblank_start
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [31:0] H_LAST = 32'(H_TOT - 1);
  localparam logic [31:0] V_LAST = 32'(V_TOT - 1);
  localparam logic [31:0] HS_B   = 32'(H_ACT + H_FP);
  localparam logic [31:0] HS_E   = 32'(H_ACT + H_FP + H_SYNC);
  localparam logic [31:0] VS_B   = 32'(V_ACT + V_FP);
  localparam logic [31:0] VS_E   = 32'(V_ACT + V_FP + V_SYNC);
  localparam logic [31:0] HACT   = 32'(H_ACT);
  localparam logic [31:0] VACT   = 32'(V_ACT);
  localparam logic [31:0] X0     = 32'(WIN_X0);
  localparam logic [31:0] Y0     = 32'(WIN_Y0);
  localparam logic [31:0] WIN_W  = 32'(2 * FB_W);
  localparam logic [31:0] WIN_H  = 32'(2 * FB_H);
  localparam logic [31:0] FBW    = 32'(FB_W);

  // Per-pixel sideband carried alongside the frame-buffer read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic in_win;
    logic vbs;      // this pixel is (V_ACT, 0): start of vertical blank
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, in_win: 1'b0, vbs: 1'b0};

  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [VW-1:0]       vcnt_q, vcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          color_q, color_d;
  logic                pix_en_q, vbs_q;
  sync_t [RD_LAT+1:0]  sr_q, sr_d;
  sync_t               cur;
  logic                pix_tick;
  logic [31:0]         h32, v32, hoff, voff;

  assign pix_tick = (div_q == DIV_MAX);
  assign h32  = 32'(hcnt_q);
  assign v32  = 32'(vcnt_q);
  // Offsets wrap to huge values left of / above the window, so one unsigned
  // compare per axis gives the window test.
  assign hoff = h32 - X0;
  assign voff = v32 - Y0;

  always_comb begin
    div_d  = pix_tick ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_tick) begin
      if (h32 == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (v32 == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur         = SYNC_RST;
    cur.hs      = !((h32 >= HS_B) && (h32 < HS_E));
    cur.vs      = !((v32 >= VS_B) && (v32 < VS_E));
    cur.blank_n = (h32 < HACT) && (v32 < VACT);
    cur.in_win  = (hoff < WIN_W) && (voff < WIN_H);
    cur.vbs     = (h32 == 32'd0) && (v32 == VACT);
  end

  // 2x replication: drop the LSB of each offset. FB_W is constant, so the
  // product reduces to shift-add.
  assign addr_d = ADDR_W'((voff >> 1) * FBW + (hoff >> 1));

  assign sr_d = {sr_q[RD_LAT:0], cur};

  // sr_q[RD_LAT] is the pixel whose RAM data is on i_fb_data this tick.
  assign color_d = (sr_q[RD_LAT].in_win && sr_q[RD_LAT].blank_n) ? i_fb_data : 4'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addr_q   <= '0;
      color_q  <= 4'd0;
      pix_en_q <= 1'b0;
      vbs_q    <= 1'b0;
      sr_q     <= {(RD_LAT+2){SYNC_RST}};
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      pix_en_q <= pix_tick;
      // Pulses on the same edge the (V_ACT,0) entry reaches the outputs.
      vbs_q    <= pix_tick && sr_q[RD_LAT].vbs;
      if (pix_tick) begin
        sr_q    <= sr_d;
        color_q <= color_d;
        if (cur.in_win) addr_q <= addr_d;
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{sr_q[RD_LAT+1].in_win, sr_q[RD_LAT+1].vbs};

  assign o_fb_addr      = addr_q;
  assign o_color_idx    = color_q;
  assign o_VGA_HS       = sr_q[RD_LAT+1].hs;
  assign o_VGA_VS       = sr_q[RD_LAT+1].vs;
  assign o_VGA_BLANK_N  = sr_q[RD_LAT+1].blank_n;
  assign o_pix_en       = pix_en_q;
  assign o_vblank_start = vbs_q;
endmodule
